spram_lsu: RTL



---
 rtl/spram_lsu.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/spram_lsu.sv
// Load/store bridge from the CPU data port to a single-port 32-bit SPRAM bank.
// One response stage backed by a one-entry skid buffer lets the CPU stall responses.
module spram_lsu #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_wen,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {EMPTY, S1, HOLD} state_e;

  state_e      state_q, state_d;
  logic        s1_load_q, s1_load_d;
  logic [1:0]  s1_size_q, s1_size_d;
  logic        s1_signed_q, s1_signed_d;
  logic [1:0]  s1_off_q, s1_off_d;
  logic        s1_err_q, s1_err_d;
  logic [31:0] hold_rdata_q, hold_rdata_d;
  logic        hold_err_q, hold_err_d;

  logic        s1_valid, hold_valid;
  logic        req_err, acc;
  logic [3:0]  lane_mask;
  logic [31:0] shifted, s1_fmt;

  assign s1_valid   = (state_q == S1);
  assign hold_valid = (state_q == HOLD);

  assign req_err = (req_size == 2'd3) |
                   ((req_size == 2'd1) & req_addr[0]) |
                   ((req_size == 2'd2) & (req_addr[1:0] != 2'b00));

  assign req_ready = resetn & !hold_valid & (!s1_valid | resp_ready);
  assign acc       = req_valid & req_ready;
  assign mem_addr  = req_addr[ADDR_W-1:2];

  always_comb begin
    lane_mask = 4'b0000;
    mem_wdata = req_wdata;
    case (req_size)
      2'd0: begin
        lane_mask = 4'b0001 << req_addr[1:0];
        mem_wdata = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        lane_mask = 4'b0011 << {req_addr[1], 1'b0};
        mem_wdata = {2{req_wdata[15:0]}};
      end
      2'd2: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  end

  // Errored requests still take a response slot but must never touch memory.
  assign mem_wen = (acc & req_we & !req_err) ? lane_mask : 4'b0000;

  assign shifted = mem_rdata >> {s1_off_q, 3'b000};

  always_comb begin
    s1_fmt = shifted;
    case (s1_size_q)
      2'd0: s1_fmt = {{24{s1_signed_q & shifted[7]}}, shifted[7:0]};
      2'd1: s1_fmt = {{16{s1_signed_q & shifted[15]}}, shifted[15:0]};
      default: s1_fmt = shifted;
    endcase
    if (!s1_load_q || s1_err_q) begin
      s1_fmt = 32'd0;
    end
  end

  assign resp_valid = s1_valid | hold_valid;
  assign resp_rdata = hold_valid ? hold_rdata_q : (s1_valid ? s1_fmt : 32'd0);
  assign resp_err   = hold_valid ? hold_err_q : (s1_valid & s1_err_q);

  always_comb begin
    state_d      = state_q;
    s1_load_d    = s1_load_q;
    s1_size_d    = s1_size_q;
    s1_signed_d  = s1_signed_q;
    s1_off_d     = s1_off_q;
    s1_err_d     = s1_err_q;
    hold_rdata_d = hold_rdata_q;
    hold_err_d   = hold_err_q;
    case (state_q)
      EMPTY: if (acc) state_d = S1;
      S1: begin
        if (!resp_ready) begin
          // RAM output will move on with the next address, so freeze the formatted word now.
          state_d      = HOLD;
          hold_rdata_d = s1_fmt;
          hold_err_d   = s1_err_q;
        end else if (!acc) begin
          state_d = EMPTY;
        end
      end
      HOLD: if (resp_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (acc) begin
      s1_load_d   = !req_we;
      s1_size_d   = req_size;
      s1_signed_d = req_signed;
      s1_off_d    = req_addr[1:0];
      s1_err_d    = req_err;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= EMPTY;
      s1_load_q    <= 1'b0;
      s1_size_q    <= 2'd0;
      s1_signed_q  <= 1'b0;
      s1_off_q     <= 2'd0;
      s1_err_q     <= 1'b0;
      hold_rdata_q <= 32'd0;
      hold_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_load_q    <= s1_load_d;
      s1_size_q    <= s1_size_d;
      s1_signed_q  <= s1_signed_d;
      s1_off_q     <= s1_off_d;
      s1_err_q     <= s1_err_d;
      hold_rdata_q <= hold_rdata_d;
      hold_err_q   <= hold_err_d;
    end
  end

endmodule
